// File: rtl/seven_seg_pkg.sv
// Shared segment encodings and helpers for the 7-segment scan controller.
// Segment bit order is a..g on bits 6..0, active-high.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h7E;
  localparam seg_t SEG_1     = 7'h30;
  localparam seg_t SEG_2     = 7'h6D;
  localparam seg_t SEG_3     = 7'h79;
  localparam seg_t SEG_4     = 7'h33;
  localparam seg_t SEG_5     = 7'h5B;
  localparam seg_t SEG_6     = 7'h5F;
  localparam seg_t SEG_7     = 7'h70;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h73;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h1F;
  localparam seg_t SEG_C     = 7'h4E;
  localparam seg_t SEG_D     = 7'h3D;
  localparam seg_t SEG_E     = 7'h4F;
  localparam seg_t SEG_F     = 7'h47;
  localparam seg_t SEG_BLANK = 7'h00;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// Registered hex-to-segment decoder with blanking, shared by all digits.
// One cycle from nibble/blank/dp input to SEG_OUT/DP_OUT.
module seg_digit_decode
  import seven_seg_pkg::*;
(
  input  logic       CLK_IN,
  input  logic       RST_IN,
  input  logic [3:0] NIB_IN,
  input  logic       BLANK_IN,
  input  logic       DP_IN,
  output seg_t       SEG_OUT,
  output logic       DP_OUT
);

  seg_t w_seg;
  seg_t r_seg;
  logic r_dp;

  assign w_seg = BLANK_IN ? SEG_BLANK : hex_to_seg(NIB_IN);

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b0;
    end else begin
      r_seg <= w_seg;
      r_dp  <= DP_IN;
    end
  end

  assign SEG_OUT = r_seg;
  assign DP_OUT  = r_dp;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-seg scan controller: slot timing, double-buffered frame load,
// leading-zero suppression and dead-time blanked digit enables.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 50000,
  parameter int BLANK_CYCLES     = 500,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                      CLK_IN,
  input  logic                      RST_IN,
  input  logic [4*NUM_DIGITS-1:0]   DATA_IN,
  input  logic [NUM_DIGITS-1:0]     DP_IN,
  input  logic                      LZ_EN_IN,
  input  logic                      LOAD_VALID_IN,
  output logic                      LOAD_READY_OUT,
  output logic [6:0]                SEG_OUT,
  output logic                      DP_OUT,
  output logic [NUM_DIGITS-1:0]     DIGIT_EN_OUT,
  output logic                      FRAME_OUT
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]          r_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_frame;
  logic [NUM_DIGITS-1:0]     r_en;
  logic                      r_pend_full;
  logic [4*NUM_DIGITS-1:0]   r_pend_dat;
  logic [NUM_DIGITS-1:0]     r_pend_dp;
  logic [4*NUM_DIGITS-1:0]   r_disp_dat;
  logic [NUM_DIGITS-1:0]     r_disp_dp;

  logic                      w_slot_end;
  logic                      w_frame_wrap;
  logic                      w_load_acc;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic [IDX_W-1:0]          w_idx_nxt;
  phase_t                    w_phase_nxt;
  logic [NUM_DIGITS-1:0]     w_en_nxt;
  logic [3:0]                w_nibs [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]     w_zero_above;
  logic [3:0]                w_nib;
  logic                      w_dp;
  logic                      w_lz_blank;
  seg_t                      w_seg;

  assign w_slot_end   = (r_cnt == CNT_MAX);
  assign w_frame_wrap = w_slot_end && (r_idx == IDX_MAX);
  assign w_load_acc   = LOAD_VALID_IN && !r_pend_full;

  // Enables are computed from next-cycle cnt/idx so the registered enable lines up with cnt.
  always_comb begin
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_phase_nxt = PH_SHOW;
    w_en_nxt    = '0;
    if (w_slot_end) begin
      w_cnt_nxt = '0;
      w_idx_nxt = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end
    if (w_cnt_nxt < CNT_BLANK) begin
      w_phase_nxt = PH_BLANK;
    end
    if (w_phase_nxt == PH_SHOW) begin
      w_en_nxt[w_idx_nxt] = 1'b1;
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_frame <= 1'b0;
      r_en    <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_frame <= w_frame_wrap;
      r_en    <= w_en_nxt;
    end
  end

  // Commit and accept never coincide: accept needs an empty pending buffer, commit a full one.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      r_pend_full <= 1'b0;
      r_pend_dat  <= '0;
      r_pend_dp   <= '0;
      r_disp_dat  <= '0;
      r_disp_dp   <= '0;
    end else begin
      if (w_load_acc) begin
        r_pend_full <= 1'b1;
        r_pend_dat  <= DATA_IN;
        r_pend_dp   <= DP_IN;
      end else if (w_frame_wrap && r_pend_full) begin
        r_pend_full <= 1'b0;
        r_disp_dat  <= r_pend_dat;
        r_disp_dp   <= r_pend_dp;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign w_nibs[g]       = r_disp_dat[4*g +: 4];
    assign w_zero_above[g] = (r_disp_dat[4*NUM_DIGITS-1:4*g] == '0);
  end

  assign w_nib      = w_nibs[r_idx];
  assign w_dp       = r_disp_dp[r_idx];
  assign w_lz_blank = LZ_EN_IN && (r_idx != '0) && w_zero_above[r_idx];

  seg_digit_decode u_decode (
    .CLK_IN   (CLK_IN),
    .RST_IN   (RST_IN),
    .NIB_IN   (w_nib),
    .BLANK_IN (w_lz_blank),
    .DP_IN    (w_dp),
    .SEG_OUT  (w_seg),
    .DP_OUT   (DP_OUT)
  );

  assign SEG_OUT        = w_seg;
  assign LOAD_READY_OUT = !r_pend_full;
  assign FRAME_OUT      = r_frame;
  assign DIGIT_EN_OUT   = (DIGIT_ACTIVE_LOW != 0) ? ~r_en : r_en;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, active-low enables.
module tb_seven_seg_scan_ctrl;

  logic        CLK_IN;
  logic        RST_IN;
  logic [15:0] DATA_IN;
  logic [3:0]  DP_IN;
  logic        LZ_EN_IN;
  logic        LOAD_VALID_IN;
  logic        LOAD_READY_OUT;
  logic [6:0]  SEG_OUT;
  logic        DP_OUT;
  logic [3:0]  DIGIT_EN_OUT;
  logic        FRAME_OUT;

  int n_total = 0;
  int n_pass  = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS       (4),
    .SCAN_DIV         (8),
    .BLANK_CYCLES     (2),
    .DIGIT_ACTIVE_LOW (1)
  ) dut (
    .CLK_IN         (CLK_IN),
    .RST_IN         (RST_IN),
    .DATA_IN        (DATA_IN),
    .DP_IN          (DP_IN),
    .LZ_EN_IN       (LZ_EN_IN),
    .LOAD_VALID_IN  (LOAD_VALID_IN),
    .LOAD_READY_OUT (LOAD_READY_OUT),
    .SEG_OUT        (SEG_OUT),
    .DP_OUT         (DP_OUT),
    .DIGIT_EN_OUT   (DIGIT_EN_OUT),
    .FRAME_OUT      (FRAME_OUT)
  );

  initial begin
    CLK_IN = 1'b0;
    forever #5 CLK_IN = ~CLK_IN;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK_IN);
  endtask

  task automatic offer(input logic [15:0] dat, input logic [3:0] dp);
    DATA_IN       = dat;
    DP_IN         = dp;
    LOAD_VALID_IN = 1'b1;
    @(negedge CLK_IN);
    LOAD_VALID_IN = 1'b0;
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK_IN);
      if (FRAME_OUT === 1'b1) break;
    end
    chk("frame_seen", FRAME_OUT, 1);
  endtask

  // Called on the negedge where FRAME_OUT is high (cnt=0, idx=0); returns one frame later.
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps);
    logic [3:0] one;
    one = 4'b0001;
    for (int k = 0; k < 32; k++) begin
      int cnt;
      int idx;
      logic [3:0] exp_en;
      cnt = k % 8;
      idx = k / 8;
      exp_en = (cnt >= 2) ? ~(one << idx) : 4'hF;
      chk($sformatf("%s_en_k%0d", tag, k), DIGIT_EN_OUT, exp_en);
      chk($sformatf("%s_frame_k%0d", tag, k), FRAME_OUT, (k == 0) ? 1 : 0);
      if (cnt >= 2) begin
        chk($sformatf("%s_seg_k%0d", tag, k), SEG_OUT, segs[7*idx +: 7]);
        chk($sformatf("%s_dp_k%0d", tag, k), DP_OUT, dps[idx]);
      end
      @(negedge CLK_IN);
    end
  endtask

  logic [6:0] prev_seg;
  logic       prev_act;
  initial begin
    prev_seg = '0;
    prev_act = 1'b0;
  end

  always @(negedge CLK_IN) begin
    if (!RST_IN) begin
      chk("en_onehot", ($countones(~DIGIT_EN_OUT) <= 1) ? 1 : 0, 1);
      if (prev_act && (DIGIT_EN_OUT != 4'hF)) chk("seg_stable", SEG_OUT, prev_seg);
    end
    prev_seg = SEG_OUT;
    prev_act = !RST_IN && (DIGIT_EN_OUT != 4'hF);
  end

  initial begin
    RST_IN        = 1'b1;
    DATA_IN       = '0;
    DP_IN         = '0;
    LZ_EN_IN      = 1'b0;
    LOAD_VALID_IN = 1'b0;
    #1;
    chk("rst_ready", LOAD_READY_OUT, 1);
    chk("rst_seg", SEG_OUT, 7'h00);
    chk("rst_dp", DP_OUT, 0);
    chk("rst_en", DIGIT_EN_OUT, 4'hF);
    chk("rst_frame", FRAME_OUT, 0);
    step(3);
    RST_IN = 1'b0;

    // All-zero display after reset.
    wait_frame();
    check_frame("zeros", {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b0000);

    // Mid-frame load, committed at the next wrap.
    step(5);
    offer(16'h1A3F, 4'b0010);
    chk("load_busy", LOAD_READY_OUT, 0);
    wait_frame();
    chk("commit_ready", LOAD_READY_OUT, 1);
    check_frame("f1a3f", {7'h30, 7'h77, 7'h79, 7'h47}, 4'b0010);

    // Second offer while busy is ignored.
    step(3);
    offer(16'h5678, 4'b0001);
    chk("b_busy", LOAD_READY_OUT, 0);
    DATA_IN = 16'h9999;
    DP_IN = 4'hF;
    LOAD_VALID_IN = 1'b1;
    step(3);
    LOAD_VALID_IN = 1'b0;
    wait_frame();
    check_frame("f5678", {7'h5B, 7'h5F, 7'h70, 7'h7F}, 4'b0001);

    // Offer in the wrap cycle lands one frame later.
    step(31);
    DATA_IN = 16'hBCDE;
    DP_IN = 4'b1000;
    LOAD_VALID_IN = 1'b1;
    @(negedge CLK_IN);
    LOAD_VALID_IN = 1'b0;
    chk("wrap_busy", LOAD_READY_OUT, 0);
    check_frame("wrap_old", {7'h5B, 7'h5F, 7'h70, 7'h7F}, 4'b0001);
    chk("wrap_ready", LOAD_READY_OUT, 1);
    check_frame("fbcde", {7'h1F, 7'h4E, 7'h3D, 7'h4F}, 4'b1000);

    // Leading-zero suppression.
    step(5);
    LZ_EN_IN = 1'b1;
    offer(16'h0040, 4'b0000);
    wait_frame();
    check_frame("lz0040", {7'h00, 7'h00, 7'h33, 7'h7E}, 4'b0000);
    step(5);
    offer(16'h0000, 4'b0000);
    wait_frame();
    check_frame("lz0000", {7'h00, 7'h00, 7'h00, 7'h7E}, 4'b0000);
    LZ_EN_IN = 1'b0;
    check_frame("nolz", {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b0000);

    // Async reset mid-SHOW with a frame still pending.
    step(5);
    offer(16'h1A3F, 4'b0010);
    step(6);
    chk("pre_rst_en", DIGIT_EN_OUT, 4'b1101);
    #2;
    RST_IN = 1'b1;
    #1;
    chk("arst_seg", SEG_OUT, 7'h00);
    chk("arst_dp", DP_OUT, 0);
    chk("arst_en", DIGIT_EN_OUT, 4'hF);
    chk("arst_frame", FRAME_OUT, 0);
    chk("arst_ready", LOAD_READY_OUT, 1);
    step(2);
    RST_IN = 1'b0;
    wait_frame();
    check_frame("post_rst", {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
